axi_wr_rd_checker: RTL and testbench

//  Self-checking AXI master. Replaces the forced-signal fake CPU upstream of axi_sram_bridge.
//  On start, it walks num_beats 64-bit addresses from base_addr. For each address it writes one

---
 rtl/axi_wr_rd_checker_pkg.sv | 19 +
 rtl/axi_wr_rd_checker_timer.sv | 27 ++
 rtl/axi_wr_rd_checker.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_wr_rd_checker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_rd_checker_pkg.sv
// Shared FSM encoding and fixed AXI field values for the write/read-back checker.
package axi_wr_rd_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RA,
        ST_RD,
        ST_FIN
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [7:0] AXI_STRB_ALL   = 8'hFF;

endpackage

// File: rtl/axi_wr_rd_checker_timer.sv
// Handshake wait timer: down-counter reloaded to TIMEOUT, tc flags that the budget is spent.
module axi_wr_rd_checker_timer
    import axi_wr_rd_checker_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            cnt <= CW'(TIMEOUT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/axi_wr_rd_checker.sv
// Self-checking AXI master: writes a per-address pattern with single-beat bursts,
// reads each one back and reports pass, error count and the first failing address.
//
// state   | meaning
// IDLE    | waiting for start
// WR      | AW and W outstanding, each dropped after its own handshake
// WB      | waiting for write response
// RA      | read address outstanding
// RD      | waiting for read data, compare, advance or finish
// FIN     | one-cycle done pulse with pass valid
module axi_wr_rd_checker
    import axi_wr_rd_checker_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_beats,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [7:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    function automatic logic [DATA_W-1:0] pattern_of(input logic [ADDR_W-1:0] a,
                                                     input logic [31:0] s);
        return DATA_W'({a ^ ADDR_W'(s), a});
    endfunction

    state_t            state;
    logic [15:0]       idx;
    logic [15:0]       n_r;
    logic [31:0]       seed_r;
    logic [ADDR_W-1:0] cur_addr;
    logic              beat_err;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any;
    logic tmr_load, tmr_tc, abort, rd_bad, err_now;
    logic [ADDR_W-1:0] start_addr, next_addr;

    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = AXI_SIZE_8B;
    assign awburst = AXI_BURST_INCR;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = AXI_SIZE_8B;
    assign arburst = AXI_BURST_INCR;
    assign wstrb   = AXI_STRB_ALL;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign hs_any = aw_hs || w_hs || b_hs || ar_hs || r_hs;

    assign start_addr = base_addr & ~ADDR_W'(7);
    assign next_addr  = cur_addr + ADDR_W'(8);

    // A beat already flagged by its write response is not counted again on read.
    assign rd_bad  = (rdata != pattern_of(cur_addr, seed_r)) || (rresp != AXI_RESP_OKAY) || !rlast;
    assign err_now = (b_hs && (bresp != AXI_RESP_OKAY)) || (r_hs && rd_bad && !beat_err);

    assign tmr_load = hs_any || (state == ST_IDLE) || (state == ST_FIN);
    assign abort    = tmr_tc && !hs_any &&
                      (state == ST_WR || state == ST_WB || state == ST_RA || state == ST_RD);

    axi_wr_rd_checker_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .load   (tmr_load),
        .tc     (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            n_r       <= '0;
            seed_r    <= '0;
            cur_addr  <= '0;
            beat_err  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wlast     <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (err_now) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err_cnt == '0) fail_addr <= cur_addr;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        timeout   <= 1'b0;
                        pass      <= 1'b0;
                        idx       <= '0;
                        n_r       <= num_beats;
                        seed_r    <= seed;
                        cur_addr  <= start_addr;
                        beat_err  <= 1'b0;
                        if (num_beats == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state   <= ST_WR;
                            busy    <= 1'b1;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            wlast   <= 1'b1;
                            awaddr  <= start_addr;
                            wdata   <= pattern_of(start_addr, seed);
                        end
                    end
                end
                ST_WR: begin
                    if (aw_hs) awvalid <= 1'b0;
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        wlast  <= 1'b0;
                    end
                    if ((!awvalid || aw_hs) && (!wvalid || w_hs)) begin
                        bready <= 1'b1;
                        state  <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (b_hs) begin
                        if (bresp != AXI_RESP_OKAY) beat_err <= 1'b1;
                        bready  <= 1'b0;
                        arvalid <= 1'b1;
                        araddr  <= cur_addr;
                        state   <= ST_RA;
                    end
                end
                ST_RA: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (r_hs) begin
                        rready <= 1'b0;
                        if (idx + 16'd1 == n_r) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_cnt == '0) && !err_now;
                        end else begin
                            idx      <= idx + 16'd1;
                            cur_addr <= next_addr;
                            beat_err <= 1'b0;
                            awvalid  <= 1'b1;
                            wvalid   <= 1'b1;
                            wlast    <= 1'b1;
                            awaddr   <= next_addr;
                            wdata    <= pattern_of(next_addr, seed_r);
                            state    <= ST_WR;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            // A stalled handshake abandons the run from whichever wait state it hit.
            if (abort) begin
                timeout <= 1'b1;
                awvalid <= 1'b0;
                wvalid  <= 1'b0;
                wlast   <= 1'b0;
                bready  <= 1'b0;
                arvalid <= 1'b0;
                rready  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
                state   <= ST_FIN;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_rd_checker.sv
// Bench for axi_wr_rd_checker: randomized AXI slave with fault injection and a beat-level model.
module tb_axi_wr_rd_checker;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_beats = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;
    logic [31:0] fail_addr;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [63:0] wdata;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [63:0] rdata = '0;

    axi_wr_rd_checker #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .num_beats(num_beats), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_cnt(err_cnt), .fail_addr(fail_addr),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input int i);
        return (b & 32'hFFFF_FFF8) + 32'(8 * i);
    endfunction

    function automatic logic [63:0] exp_pat(input logic [31:0] a, input logic [31:0] s);
        return {a ^ s, a};
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    // slave configuration and per-run bookkeeping
    int          rdy_pct = 100;
    int          err_pct = 0;
    int          corrupt_beat = -1;
    bit          stall = 0;
    bit          w_lag = 0;
    logic [31:0] run_base = '0;
    logic [31:0] run_seed = '0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          beat_bad [int];

    bit          aw_got = 0, w_got = 0, wr_pending = 0, rd_pending = 0, aw_prev = 0;
    bit          aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
    int          lag = 0;
    logic [31:0] wr_addr = '0, rd_addr = '0;
    logic [63:0] wr_data = '0;
    logic [63:0] mem [logic [31:0]];

    // Runs at negedge; fire flags describe handshakes that complete at the next posedge.
    task automatic slave_step();
        if (!resetn) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            bresp = 0; rresp = 0; rlast = 0; rdata = 0;
            aw_got = 0; w_got = 0; wr_pending = 0; rd_pending = 0; aw_prev = 0; lag = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            return;
        end
        if (b_fire) bvalid = 0;
        if (r_fire) begin
            rvalid = 0;
            rlast  = 0;
        end
        if (w_lag && aw_prev) check_val("aw_drops_first", {62'd0, awvalid, wvalid}, 64'h1);
        if (w_lag && wvalid && aw_got && !w_got)
            check_val("wdata_stable", wdata, exp_pat(exp_addr(run_base, w_cnt), run_seed));
        aw_prev = 0;

        if (wr_pending && !bvalid && roll(rdy_pct)) begin
            bresp = 2'b00;
            if (roll(err_pct)) begin
                bresp = 2'($urandom_range(1, 3));
                beat_bad[w_cnt-1] = 1;
            end
            bvalid = 1;
            wr_pending = 0;
        end
        if (rd_pending && !rvalid && roll(rdy_pct)) begin
            rdata = mem.exists(rd_addr) ? mem[rd_addr] : 64'h0;
            rresp = 2'b00;
            rlast = 1;
            if (ar_cnt - 1 == corrupt_beat) begin
                rdata[0] = ~rdata[0];
                beat_bad[ar_cnt-1] = 1;
            end
            if (roll(err_pct)) begin
                case ($urandom_range(0, 2))
                    0:       rdata = rdata ^ (64'd1 << $urandom_range(0, 63));
                    1:       rresp = 2'($urandom_range(1, 3));
                    default: rlast = 0;
                endcase
                beat_bad[ar_cnt-1] = 1;
            end
            rvalid = 1;
            rd_pending = 0;
        end

        if (w_lag && aw_got && !w_got) lag++;
        if (stall) begin
            awready = 0; wready = 0; arready = 0;
        end else begin
            awready = roll(rdy_pct);
            wready  = w_lag ? (aw_got && lag >= 3) : roll(rdy_pct);
            arready = roll(rdy_pct);
        end

        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        b_fire  = bvalid && bready;
        ar_fire = arvalid && arready;
        r_fire  = rvalid && rready;
        if (aw_fire) begin
            check_val("awaddr", {32'd0, awaddr}, {32'd0, exp_addr(run_base, aw_cnt)});
            wr_addr = awaddr;
            aw_got  = 1;
            aw_cnt++;
            aw_prev = !w_fire;
            lag = 0;
        end
        if (w_fire) begin
            check_val("wdata", wdata, exp_pat(exp_addr(run_base, w_cnt), run_seed));
            wr_data = wdata;
            w_got   = 1;
            w_cnt++;
        end
        if (aw_got && w_got) begin
            mem[wr_addr] = wr_data;
            aw_got = 0;
            w_got  = 0;
            wr_pending = 1;
        end
        if (ar_fire) begin
            check_val("araddr", {32'd0, araddr}, {32'd0, exp_addr(run_base, ar_cnt)});
            rd_addr = araddr;
            ar_cnt++;
            rd_pending = 1;
        end
        if (r_fire) r_cnt++;
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    task automatic check_reset_state(input string tag);
        check_val({tag, ".status"}, {14'd0, busy, done, pass, timeout, err_cnt, fail_addr}, 64'h0);
        check_val({tag, ".ctrl"}, {58'd0, awvalid, wvalid, wlast, bready, arvalid, rready}, 64'h0);
        check_val({tag, ".addr"}, {awaddr, araddr}, 64'h0);
        check_val({tag, ".wdata"}, wdata, 64'h0);
    endtask

    task automatic begin_run(input logic [31:0] b, input int n, input logic [31:0] s);
        run_base = b; run_seed = s;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        beat_bad.delete();
        base_addr = b; num_beats = 16'(n); seed = s;
        start = 1;
        @(posedge clk); #2;
        start = 0;
    endtask

    // exp_lat < 0 skips the cycle-exact latency check
    task automatic run_chk(input string name, input logic [31:0] b, input int n,
                           input logic [31:0] s, input int exp_lat);
        int cyc;
        int exp_err;
        int first;
        logic [31:0] exp_fail;
        begin_run(b, n, s);
        if (n > 0) check_val({name, ".busy"}, {63'd0, busy}, 64'h1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_val({name, ".done"}, {63'd0, done}, 64'h1);
        if (exp_lat >= 0) check_val({name, ".latency"}, 64'(cyc), 64'(exp_lat));
        exp_err = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (beat_bad.exists(i)) begin
                exp_err++;
                if (first < 0) first = i;
            end
        end
        if (stall) begin
            exp_err = 0;
            first = -1;
        end
        exp_fail = (first < 0) ? 32'd0 : exp_addr(b, first);
        check_val({name, ".timeout"}, {63'd0, timeout}, {63'd0, stall});
        check_val({name, ".err_cnt"}, {48'd0, err_cnt}, 64'(exp_err));
        check_val({name, ".fail_addr"}, {32'd0, fail_addr}, {32'd0, exp_fail});
        check_val({name, ".pass"}, {63'd0, pass}, {63'd0, (exp_err == 0) && !stall});
        check_val({name, ".busy_end"}, {63'd0, busy}, 64'h0);
        if (stall) begin
            check_val({name, ".valids_off"},
                      {58'd0, awvalid, wvalid, wlast, bready, arvalid, rready}, 64'h0);
        end else begin
            check_val({name, ".beats"}, {32'(aw_cnt), 32'(r_cnt)}, {32'(n), 32'(n)});
        end
        @(posedge clk); #2;
        check_val({name, ".done_pulse"}, {62'd0, done, pass},
                  {62'd0, 1'b0, (exp_err == 0) && !stall});
        if (cyc >= 20000) begin
            resetn = 0;
            @(posedge clk); #2;
            resetn = 1;
        end
    endtask

    initial begin
        int cyc;
        resetn = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset");
        check_val("consts", {awlen, awsize, awburst, wstrb, arlen, arsize, arburst, 10'd0},
                  {8'd0, 3'd3, 2'b01, 8'hFF, 8'd0, 3'd3, 2'b01, 10'd0});
        resetn = 1;
        @(posedge clk); #2;

        run_chk("t1_align", 32'h0000_0004, 1, 32'h0, 4);
        run_chk("t2_seq16", 32'h0000_0100, 16, 32'hA5A5_A5A5, 64);
        corrupt_beat = 5;
        run_chk("t3_corrupt", 32'h0000_0100, 16, 32'hA5A5_A5A5, 64);
        corrupt_beat = -1;
        run_chk("t4_wrap", 32'hFFFF_FFF8, 2, 32'h1234_5678, 8);
        run_chk("t_zero", 32'h0000_0040, 0, 32'h0, 0);

        stall = 1;
        run_chk("t5_timeout", 32'h0000_1000, 3, 32'h0, TIMEOUT + 1);
        stall = 0;

        begin_run(32'h0000_0200, 8, 32'hCAFE_F00D);
        cyc = 0;
        while (!(ar_cnt == 4 && rready) && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_val("t6.in_rd", {63'd0, rready}, 64'h1);
        resetn = 0;
        @(posedge clk); #2;
        check_reset_state("t6_reset");
        resetn = 1;
        @(posedge clk); #2;
        run_chk("t6_clean", 32'h0000_0200, 8, 32'hCAFE_F00D, 32);

        w_lag = 1;
        run_chk("t7_wlag", 32'h0000_0800, 4, 32'h0F0F_0F0F, -1);
        w_lag = 0;

        for (int k = 0; k < 6; k++) begin
            rdy_pct = int'($urandom_range(30, 100));
            err_pct = 25;
            run_chk($sformatf("rnd%0d", k), $urandom, int'($urandom_range(1, 20)), $urandom, -1);
        end
        err_pct = 0;
        rdy_pct = 100;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
